// File: rtl/prim_alert_ping_timer.sv
// prim_alert_ping_timer
// Periodic liveness checker for a bank of alert receivers. After a pseudo-random
// wait it selects the next enabled channel in round-robin order. It raises that
// channel's ping request and waits for the matching ping_ok pulse. If the pulse
// does not arrive within the programmed timeout, it reports a ping failure.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   en_i           ping mechanism enable (level)
//   alert_en_i     per-channel enable; disabled channels are never pinged
//   timeout_cyc_i  timeout T, sampled on ping start; request lasts at most T+1 cycles
//   ping_en_o      one-hot-or-zero ping request (level, registered)
//   ping_ok_i      per-channel ping response pulses
//   ping_fail_o    1-cycle pulse when the selected channel timed out
//   fail_idx_o     index of the most recently timed-out channel
module prim_alert_ping_timer #(
    parameter int unsigned NAlerts  = 4,
    parameter int unsigned WaitCntW = 8,
    parameter int unsigned TimeoutW = 8,
    parameter logic [15:0] LfsrSeed = 16'hACE1,
    localparam int unsigned IdxW    = (NAlerts > 1) ? $clog2(NAlerts) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [NAlerts-1:0]  alert_en_i,
    input  logic [TimeoutW-1:0] timeout_cyc_i,
    output logic [NAlerts-1:0]  ping_en_o,
    input  logic [NAlerts-1:0]  ping_ok_i,
    output logic                ping_fail_o,
    output logic [IdxW-1:0]     fail_idx_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PING = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [TimeoutW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [IdxW-1:0]     last_idx_q, last_idx_d;
    logic [IdxW-1:0]     fail_idx_q, fail_idx_d;
    logic [NAlerts-1:0]  ping_en_q, ping_en_d;
    logic                ping_fail_q, ping_fail_d;

    // Round-robin candidate search results.
    logic [IdxW-1:0]     hi_idx, lo_idx, next_idx;
    logic                hi_found, lo_found, next_found;

    // Enable and response of the currently selected channel (last_idx_q).
    logic [NAlerts-1:0]  sel_mask;
    logic                sel_en, sel_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NAlerts; gi++) begin : g_chan
            assign sel_mask[gi]  = (last_idx_q == IdxW'(gi));
            // The request follows the next state so that it is a plain register output.
            assign ping_en_d[gi] = (state_d == ST_PING) && (last_idx_d == IdxW'(gi));
        end
    endgenerate

    assign sel_en = |(alert_en_i & sel_mask);
    assign sel_ok = |(ping_ok_i & sel_mask);

    // 16-bit Galois LFSR, polynomial 0xB400. It advances only while enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Nearest enabled channel strictly after last_idx_q, wrapping around.
    // The scan runs downward so the last hit in each half is the lowest index.
    // Channels above last_idx_q take precedence over the wrapped half. The
    // wrapped half includes last_idx_q itself, for the single-channel case.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int c = NAlerts - 1; c >= 0; c--) begin
            if (alert_en_i[c]) begin
                if (IdxW'(c) > last_idx_q) begin
                    hi_idx   = IdxW'(c);
                    hi_found = 1'b1;
                end else begin
                    lo_idx   = IdxW'(c);
                    lo_found = 1'b1;
                end
            end
        end
        next_idx   = hi_found ? hi_idx : lo_idx;
        next_found = hi_found | lo_found;
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        last_idx_d  = last_idx_q;
        fail_idx_d  = fail_idx_q;
        ping_fail_d = 1'b0;

        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|alert_en_i) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = lfsr_q[WaitCntW-1:0];
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        if (next_found) begin
                            state_d    = ST_PING;
                            tmo_cnt_d  = timeout_cyc_i;
                            last_idx_d = next_idx;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q - WaitCntW'(1);
                    end
                end
                ST_PING: begin
                    if (!sel_en || sel_ok) begin
                        // The channel was disabled (abort) or it answered in time.
                        // An answer in the expiry cycle still wins over the timeout.
                        state_d    = ST_WAIT;
                        wait_cnt_d = lfsr_q[WaitCntW-1:0];
                    end else if (tmo_cnt_q == '0) begin
                        state_d     = ST_WAIT;
                        wait_cnt_d  = lfsr_q[WaitCntW-1:0];
                        ping_fail_d = 1'b1;
                        fail_idx_d  = last_idx_q;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - TimeoutW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LfsrSeed;
            wait_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            last_idx_q  <= IdxW'(NAlerts - 1);
            fail_idx_q  <= '0;
            ping_en_q   <= '0;
            ping_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            last_idx_q  <= last_idx_d;
            fail_idx_q  <= fail_idx_d;
            ping_en_q   <= ping_en_d;
            ping_fail_q <= ping_fail_d;
        end
    end

    assign ping_en_o   = ping_en_q;
    assign ping_fail_o = ping_fail_q;
    assign fail_idx_o  = fail_idx_q;

endmodule

// File: tb/tb_prim_alert_ping_timer.sv
// Directed testbench for prim_alert_ping_timer (NAlerts=4, WaitCntW=8, TimeoutW=8).
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_prim_alert_ping_timer;

    logic       clk_i         = 1'b0;
    logic       rst_ni        = 1'b0;
    logic       en_i          = 1'b0;
    logic [3:0] alert_en_i    = 4'b0;
    logic [7:0] timeout_cyc_i = 8'd0;
    logic [3:0] ping_ok_i     = 4'b0;
    logic [3:0] ping_en_o;
    logic       ping_fail_o;
    logic [1:0] fail_idx_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    prim_alert_ping_timer #(
        .NAlerts  (4),
        .WaitCntW (8),
        .TimeoutW (8),
        .LfsrSeed (16'hACE1)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .alert_en_i    (alert_en_i),
        .timeout_cyc_i (timeout_cyc_i),
        .ping_en_o     (ping_en_o),
        .ping_ok_i     (ping_ok_i),
        .ping_fail_o   (ping_fail_o),
        .fail_idx_o    (fail_idx_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-20s got %0h expected %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-20s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a ping request to appear. gap counts falling edges
    // with ping_en_o low, starting with the current one.
    task automatic wait_rise(output logic [3:0] pe, output int gap);
        gap = 0;
        while (ping_en_o == 4'b0 && gap < 400) begin
            gap++;
            @(negedge clk_i);
        end
        pe = ping_en_o;
        check_eq("ping_rise_in_time", 32'(gap < 400), 32'd1);
        check_eq("ping_onehot", 32'($onehot(pe)), 32'd1);
    endtask

    // Run one ping to completion. If ok_cyc is nonzero, ok_val is driven for
    // one cycle in request cycle ok_cyc (cycle 1 is the first one seen high).
    // hi returns the number of cycles the request was seen high. On return,
    // the current falling edge is the first one with ping_en_o low again.
    task automatic run_ping(input int ok_cyc, input logic [3:0] ok_val,
                            output logic [3:0] pe, output int hi, output int gap);
        wait_rise(pe, gap);
        hi = 1;
        if (ok_cyc == 1) ping_ok_i = ok_val;
        while (1) begin
            @(negedge clk_i);
            if (ok_cyc != 0) ping_ok_i = 4'b0;
            if (ping_en_o == 4'b0 || hi >= 300) break;
            hi++;
            if (hi == ok_cyc) ping_ok_i = ok_val;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pe;
        logic [3:0] exp_pe;
        int hi, gap, cnt;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check_eq("rst_ping_en", 32'(ping_en_o), 32'h0);
        check_eq("rst_ping_fail", 32'(ping_fail_o), 32'h0);
        check_eq("rst_fail_idx", 32'(fail_idx_o), 32'h0);
        rst_ni = 1'b1;

        // 1: round robin over ch0 and ch2; ok returned 3 cycles after each rise.
        en_i = 1'b1; alert_en_i = 4'b0101; timeout_cyc_i = 8'd10;
        for (int i = 0; i < 6; i++) begin
            exp_pe = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            run_ping(4, exp_pe, pe, hi, gap);
            check_eq("rr_channel", 32'(pe), 32'(exp_pe));
            check_eq("rr_high_cycles", 32'(hi), 32'd4);
            check_eq("rr_no_fail", 32'(ping_fail_o), 32'h0);
            if (i > 0) check_eq("rr_wait_range", 32'(gap >= 1 && gap <= 256), 32'd1);
        end

        // 2: T=5, no response on ch1 -> request high 6 cycles, then fail pulse.
        alert_en_i = 4'b0010; timeout_cyc_i = 8'd5;
        run_ping(0, 4'b0, pe, hi, gap);
        check_eq("to_channel", 32'(pe), 32'h2);
        check_eq("to_high_cycles", 32'(hi), 32'd6);
        check_eq("to_fail_pulse", 32'(ping_fail_o), 32'h1);
        check_eq("to_fail_idx", 32'(fail_idx_o), 32'd1);
        @(negedge clk_i);
        check_eq("to_fail_1cycle", 32'(ping_fail_o), 32'h0);

        // 3: ok on the 6th request cycle (timer at zero) still counts as success.
        alert_en_i = 4'b1000;
        run_ping(6, 4'b1000, pe, hi, gap);
        check_eq("late_ok_channel", 32'(pe), 32'h8);
        check_eq("late_ok_high", 32'(hi), 32'd6);
        check_eq("late_ok_no_fail", 32'(ping_fail_o), 32'h0);
        check_eq("late_ok_idx_held", 32'(fail_idx_o), 32'd1);

        // 4: ok only on other channels, T=3 -> fail after 4 cycles on ch2.
        alert_en_i = 4'b0100; timeout_cyc_i = 8'd3; ping_ok_i = 4'b1011;
        run_ping(0, 4'b0, pe, hi, gap);
        ping_ok_i = 4'b0;
        check_eq("wrong_ok_channel", 32'(pe), 32'h4);
        check_eq("wrong_ok_high", 32'(hi), 32'd4);
        check_eq("wrong_ok_fail", 32'(ping_fail_o), 32'h1);
        check_eq("wrong_ok_fail_idx", 32'(fail_idx_o), 32'd2);
        @(negedge clk_i);
        check_eq("wrong_ok_fail_1cyc", 32'(ping_fail_o), 32'h0);

        // Abort: channel disabled mid-request -> request drops, no fail.
        alert_en_i = 4'b0001; timeout_cyc_i = 8'd10;
        wait_rise(pe, gap);
        check_eq("abort_channel", 32'(pe), 32'h1);
        alert_en_i = 4'b0000;
        @(negedge clk_i);
        check_eq("abort_ping_en", 32'(ping_en_o), 32'h0);
        check_eq("abort_no_fail", 32'(ping_fail_o), 32'h0);
        cnt = 0;
        repeat (600) begin
            @(negedge clk_i);
            if (ping_en_o != 4'b0 || ping_fail_o) cnt++;
        end
        check_eq("no_chan_no_ping", 32'(cnt), 32'd0);

        // 5: en_i dropped mid-request -> request drops next cycle, no fail.
        alert_en_i = 4'b0001;
        wait_rise(pe, gap);
        check_eq("endrop_channel", 32'(pe), 32'h1);
        @(negedge clk_i);
        en_i = 1'b0;
        @(negedge clk_i);
        check_eq("endrop_ping_en", 32'(ping_en_o), 32'h0);
        check_eq("endrop_no_fail", 32'(ping_fail_o), 32'h0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (ping_en_o != 4'b0 || ping_fail_o) cnt++;
        end
        check_eq("disabled_quiet", 32'(cnt), 32'd0);
        en_i = 1'b1; alert_en_i = 4'b0000;
        cnt = 0;
        repeat (600) begin
            @(negedge clk_i);
            if (ping_en_o != 4'b0 || ping_fail_o) cnt++;
        end
        check_eq("en_no_alert_quiet", 32'(cnt), 32'd0);

        // 6: asynchronous reset mid-request, then restart from the lowest channel.
        alert_en_i = 4'b0110; timeout_cyc_i = 8'd20;
        wait_rise(pe, gap);
        check_eq("pre_rst_channel", 32'(pe), 32'h2);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_ping_en", 32'(ping_en_o), 32'h0);
        check_eq("arst_ping_fail", 32'(ping_fail_o), 32'h0);
        check_eq("arst_fail_idx", 32'(fail_idx_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pe = (i % 2 == 0) ? 4'b0010 : 4'b0100;
            run_ping(4, exp_pe, pe, hi, gap);
            check_eq("post_rst_channel", 32'(pe), 32'(exp_pe));
            check_eq("post_rst_no_fail", 32'(ping_fail_o), 32'h0);
            if (i > 0) check_eq("post_rst_wait_rng", 32'(gap >= 1 && gap <= 256), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
